// File: rtl/decode_queue.sv
// Decodes a bundle of instructions per lane and buffers decoded bundles in a DEPTH-entry FIFO.
// Latency: a bundle accepted into an empty queue appears at the execute outputs one cycle later.
// Backpressure: fetch_ready_out = free entry available, from registered state only (no path from execute_ready_in).

package processor_help;
  localparam int SUPER_SCALAR_WIDTH = 2;

  typedef logic [31:0] Word;

  // Opcode values carried in instruction bits [3:0]
  localparam logic [3:0] OPC_OP     = 4'h1;
  localparam logic [3:0] OPC_OP_IMM = 4'h2;
  localparam logic [3:0] OPC_LOAD   = 4'h3;
  localparam logic [3:0] OPC_STORE  = 4'h4;
  localparam logic [3:0] OPC_BRANCH = 4'h5;

  // Field map: [3:0] opcode, [6:4] funct, [11:7] rd, [16:12] rs1, [21:17] rs2,
  // I-type immediate [31:20], S/B-type immediate {[31:25],[11:7]}; both sign-extended.
  typedef enum logic [2:0] {
    UNSUPPORTED  = 3'd0,
    OP_NORMAL    = 3'd1,
    OP_IMMEDIATE = 3'd2,
    LOAD         = 3'd3,
    STORE        = 3'd4,
    BRANCH       = 3'd5
  } InstructionType;

  // Encoded so that alu_operation = funct + 1 for the ALU funct codes 3'b000..3'b110
  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_SLL  = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_AND  = 3'd6,
    ALU_OR   = 3'd7
  } AluOperation;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4
  } BranchOperation;

  typedef struct packed {
    InstructionType instruction_type;
    AluOperation    alu_operation;
    BranchOperation branch_operation;
    logic [4:0]     rd;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    Word            immediate;
  } DecodeResult;
endpackage

module decode_queue #(
  parameter int LANES = processor_help::SUPER_SCALAR_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    flush_in,
  output logic                                    fetch_ready_out,
  input  logic                                    fetch_valid_in,
  input  logic [LANES-1:0]                        fetch_mask_in,
  input  processor_help::Word [LANES-1:0]         fetch_data_in,
  input  logic                                    execute_ready_in,
  output logic                                    execute_valid_out,
  output logic [LANES-1:0]                        execute_mask_out,
  output processor_help::DecodeResult [LANES-1:0] execute_payload_out,
  output logic [$clog2(DEPTH):0]                  occupancy_out,
  output logic [CNT_W-1:0]                        unsupported_count_out
);
  import processor_help::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [LANES-1:0] mask_mem [DEPTH];
  DecodeResult [LANES-1:0] pay_mem [DEPTH];

  DecodeResult [LANES-1:0] dec_bundle;
  logic [LANES-1:0] dec_unsup;
  logic [CNT_W:0]   unsup_sum;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] unsup_cnt;
  logic             enq;
  logic             deq;
  logic             store;

  // Unknown opcode/funct collapses to an all-zero UNSUPPORTED result.
  function automatic DecodeResult decode_word(input Word instr);
    DecodeResult r;
    logic [2:0]  funct;
    logic        ok;
    r     = '0;
    funct = instr[6:4];
    ok    = 1'b0;
    case (instr[3:0])
      OPC_OP: begin
        ok                 = (funct != 3'b111);
        r.instruction_type = OP_NORMAL;
        r.alu_operation    = AluOperation'(funct + 3'd1);
        r.rd               = instr[11:7];
        r.rs1              = instr[16:12];
        r.rs2              = instr[21:17];
      end
      OPC_OP_IMM: begin
        // No register-immediate subtract: funct 3'b001 is illegal here.
        ok                 = (funct != 3'b111) && (funct != 3'b001);
        r.instruction_type = OP_IMMEDIATE;
        r.alu_operation    = AluOperation'(funct + 3'd1);
        r.rd               = instr[11:7];
        r.rs1              = instr[16:12];
        r.immediate        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LOAD: begin
        ok                 = (funct == 3'b010);
        r.instruction_type = LOAD;
        r.rd               = instr[11:7];
        r.rs1              = instr[16:12];
        r.immediate        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        ok                 = (funct == 3'b010);
        r.instruction_type = STORE;
        r.rs1              = instr[16:12];
        r.rs2              = instr[21:17];
        r.immediate        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        ok                 = 1'b1;
        r.instruction_type = BRANCH;
        r.rs1              = instr[16:12];
        r.rs2              = instr[21:17];
        r.immediate        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        case (funct)
          3'b000:  r.branch_operation = BR_EQ;
          3'b001:  r.branch_operation = BR_NE;
          3'b100:  r.branch_operation = BR_LT;
          3'b101:  r.branch_operation = BR_GE;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r = '0;
    end
    return r;
  endfunction

  assign fetch_ready_out       = (count < FULL_CNT);
  assign execute_valid_out     = (count != '0);
  assign execute_mask_out      = mask_mem[rd_ptr];
  assign execute_payload_out   = pay_mem[rd_ptr];
  assign occupancy_out         = count;
  assign unsupported_count_out = unsup_cnt;

  assign enq   = fetch_valid_in && fetch_ready_out;
  assign deq   = execute_valid_out && execute_ready_in;
  // An all-lanes-off bundle is accepted but occupies no entry.
  assign store = enq && (|fetch_mask_in);

  // Decode all lanes; masked-off lanes carry a zero payload and never count as unsupported.
  always_comb begin
    dec_bundle = '0;
    dec_unsup  = '0;
    unsup_sum  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (fetch_mask_in[l]) begin
        dec_bundle[l] = decode_word(fetch_data_in[l]);
        dec_unsup[l]  = (dec_bundle[l].instruction_type == UNSUPPORTED);
      end
      unsup_sum = unsup_sum + (CNT_W+1)'(dec_unsup[l]);
    end
    cnt_sum = {1'b0, unsup_cnt} + unsup_sum;
  end

  // Pointers and occupancy; flush overrides both handshakes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (deq)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Mask storage is reset so the head mask reads zero out of reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) mask_mem[i] <= '0;
    end else if (store && !flush_in) begin
      mask_mem[wr_ptr] <= fetch_mask_in;
    end
  end

  // Payload storage needs no reset: it is only observed behind execute_valid_out.
  always_ff @(posedge clk_in) begin
    if (store && !flush_in) pay_mem[wr_ptr] <= dec_bundle;
  end

  // Saturating unsupported-lane counter; flush leaves it alone and drops the flushed bundle's lanes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      unsup_cnt <= '0;
    end else if (enq && !flush_in) begin
      unsup_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: queue-based reference model checked every cycle, plus literal spot checks.
// Inputs change 2 time units after each rising edge; outputs are compared on the falling edge.
// Covers decode, ordering across wrap, full/empty, throughput, counter saturation, flush and async reset.
module tb_decode_queue;
  import processor_help::*;

  localparam int LN = 2;
  localparam int DP = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic flush_in = 1'b0;
  logic fetch_ready_out;
  logic fetch_valid_in = 1'b0;
  logic [LN-1:0] fetch_mask_in = '0;
  Word [LN-1:0] fetch_data_in = '0;
  logic execute_ready_in = 1'b0;
  logic execute_valid_out;
  logic [LN-1:0] execute_mask_out;
  DecodeResult [LN-1:0] execute_payload_out;
  logic [2:0] occupancy_out;
  logic [15:0] unsupported_count_out;

  decode_queue #(.LANES(LN), .DEPTH(DP), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .fetch_ready_out(fetch_ready_out), .fetch_valid_in(fetch_valid_in),
    .fetch_mask_in(fetch_mask_in), .fetch_data_in(fetch_data_in),
    .execute_ready_in(execute_ready_in), .execute_valid_out(execute_valid_out),
    .execute_mask_out(execute_mask_out), .execute_payload_out(execute_payload_out),
    .occupancy_out(occupancy_out), .unsupported_count_out(unsupported_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;
  int dut_deqs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [LN-1:0]        mask;
    DecodeResult [LN-1:0] pl;
  } bundle_t;

  localparam AluOperation ALU_TAB [8] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
                                          ALU_XOR, ALU_AND, ALU_OR, ALU_NONE};

  function automatic DecodeResult model_decode(input Word w);
    DecodeResult r;
    logic [3:0]  op;
    logic [2:0]  f;
    logic [11:0] s_imm;
    logic [11:0] i_imm;
    r = '0;
    op = w[3:0];
    f = w[6:4];
    s_imm = {w[31:25], w[11:7]};
    i_imm = w[31:20];
    if (op == 4'h1 && f != 3'd7) begin
      r.instruction_type = OP_NORMAL; r.alu_operation = ALU_TAB[f];
      r.rd = w[11:7]; r.rs1 = w[16:12]; r.rs2 = w[21:17];
    end else if (op == 4'h2 && f != 3'd7 && f != 3'd1) begin
      r.instruction_type = OP_IMMEDIATE; r.alu_operation = ALU_TAB[f];
      r.rd = w[11:7]; r.rs1 = w[16:12]; r.immediate = 32'($signed(i_imm));
    end else if (op == 4'h3 && f == 3'd2) begin
      r.instruction_type = LOAD;
      r.rd = w[11:7]; r.rs1 = w[16:12]; r.immediate = 32'($signed(i_imm));
    end else if (op == 4'h4 && f == 3'd2) begin
      r.instruction_type = STORE;
      r.rs1 = w[16:12]; r.rs2 = w[21:17]; r.immediate = 32'($signed(s_imm));
    end else if (op == 4'h5 && (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5)) begin
      r.instruction_type = BRANCH;
      r.rs1 = w[16:12]; r.rs2 = w[21:17]; r.immediate = 32'($signed(s_imm));
      case (f)
        3'd0:    r.branch_operation = BR_EQ;
        3'd1:    r.branch_operation = BR_NE;
        3'd4:    r.branch_operation = BR_LT;
        default: r.branch_operation = BR_GE;
      endcase
    end
    return r;
  endfunction

  bundle_t mq[$];
  int      m_cnt = 0;

  always @(posedge clk_in or negedge rst_in) begin
    bundle_t nb;
    bit m_enq, m_deq;
    int nu;
    if (!rst_in) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      m_enq = fetch_valid_in && (mq.size() < DP);
      m_deq = (mq.size() != 0) && execute_ready_in;
      if (flush_in) begin
        mq.delete();
      end else begin
        if (m_deq) void'(mq.pop_front());
        if (m_enq) begin
          nb = '0;
          nu = 0;
          nb.mask = fetch_mask_in;
          for (int l = 0; l < LN; l++) begin
            if (fetch_mask_in[l]) begin
              nb.pl[l] = model_decode(fetch_data_in[l]);
              if (nb.pl[l].instruction_type == UNSUPPORTED) nu++;
            end
          end
          if (fetch_mask_in != '0) mq.push_back(nb);
          m_cnt = (m_cnt + nu > 65535) ? 65535 : m_cnt + nu;
        end
      end
    end
  end

  always @(posedge clk_in) if (execute_valid_out && execute_ready_in) dut_deqs++;

  // Per-cycle comparison against the model
  always @(negedge clk_in) begin
    if (cmp_on) begin
      check("ready", 64'(fetch_ready_out), 64'(mq.size() < DP));
      check("valid", 64'(execute_valid_out), 64'(mq.size() != 0));
      check("occupancy", 64'(occupancy_out), 64'(mq.size()));
      check("unsup_count", 64'(unsupported_count_out), 64'(m_cnt));
      if (mq.size() != 0) begin
        check("head_mask", 64'(execute_mask_out), 64'(mq[0].mask));
        for (int l = 0; l < LN; l++)
          check($sformatf("head_payload%0d", l), 64'(execute_payload_out[l]), 64'(mq[0].pl[l]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic Word enc_r(input logic [3:0] op, input logic [2:0] f,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {10'd0, rs2, rs1, rd, f, op};
  endfunction

  function automatic Word enc_i(input logic [3:0] op, input logic [2:0] f,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, 3'd0, rs1, rd, f, op};
  endfunction

  function automatic Word enc_s(input logic [3:0] op, input logic [2:0] f,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], 3'd0, rs2, rs1, imm[4:0], f, op};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic drive(input logic [LN-1:0] m, input Word w0, input Word w1);
    fetch_mask_in = m;
    fetch_data_in[0] = w0;
    fetch_data_in[1] = w1;
  endtask

  Word        b_l0 [10];
  Word        b_l1 [10];
  logic [1:0] b_m  [10];
  Word        junk;

  initial begin
    bit acc;
    int guard;
    int d0;
    junk = 32'hDEAD_BEEF;
    b_l0[0] = enc_i(4'h2, 3'b000, 5'd1, 5'd2, 12'hFFC);  b_l1[0] = enc_r(4'h1, 3'b110, 5'd3, 5'd4, 5'd5);  b_m[0] = 2'b11;
    b_l0[1] = enc_s(4'h5, 3'b101, 5'd8, 5'd9, 12'h810);  b_l1[1] = enc_i(4'h3, 3'b010, 5'd10, 5'd11, 12'h07F); b_m[1] = 2'b11;
    b_l0[2] = enc_s(4'h4, 3'b010, 5'd12, 5'd13, 12'h123); b_l1[2] = enc_i(4'h2, 3'b001, 5'd1, 5'd1, 12'h001); b_m[2] = 2'b01;
    b_l0[3] = 32'h0000_000F;                               b_l1[3] = enc_r(4'h1, 3'b001, 5'd14, 5'd15, 5'd16); b_m[3] = 2'b10;
    for (int i = 4; i < 10; i++) begin
      b_l0[i] = enc_r(4'h1, 3'(i % 7), 5'(i), 5'(i + 1), 5'(i + 2));
      b_l1[i] = enc_i(4'h2, 3'b000, 5'(i), 5'(i), 12'(i * 100));
      b_m[i]  = 2'b11;
    end

    // Reset
    #1 rst_in = 1'b0;
    cmp_on = 1'b1;
    step(); step();
    rst_in = 1'b1;
    check("rst_valid", 64'(execute_valid_out), 64'd0);
    check("rst_mask", 64'(execute_mask_out), 64'd0);
    check("rst_occ", 64'(occupancy_out), 64'd0);
    check("rst_cnt", 64'(unsupported_count_out), 64'd0);
    check("rst_ready", 64'(fetch_ready_out), 64'd1);

    // Single bundle, lane1 masked off (its junk opcode must not count)
    drive(2'b01, enc_r(4'h1, 3'b101, 5'd5, 5'd6, 5'd7), 32'h0000_00FF);
    fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("t1_valid", 64'(execute_valid_out), 64'd1);
    check("t1_mask", 64'(execute_mask_out), 64'h1);
    check("t1_type", 64'(execute_payload_out[0].instruction_type), 64'(OP_NORMAL));
    check("t1_alu", 64'(execute_payload_out[0].alu_operation), 64'(ALU_AND));
    check("t1_br", 64'(execute_payload_out[0].branch_operation), 64'd0);
    check("t1_regs", 64'({execute_payload_out[0].rd, execute_payload_out[0].rs1, execute_payload_out[0].rs2}),
          64'({5'd5, 5'd6, 5'd7}));
    check("t1_lane1_zero", 64'(execute_payload_out[1]), 64'd0);
    check("t1_occ", 64'(occupancy_out), 64'd1);
    execute_ready_in = 1'b1;
    step();
    execute_ready_in = 1'b0;

    // Fill to full with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      drive(b_m[i], b_l0[i], b_l1[i]);
      fetch_valid_in = 1'b1;
      step();
    end
    check("full_ready", 64'(fetch_ready_out), 64'd0);
    check("full_occ", 64'(occupancy_out), 64'd4);
    check("b0_type", 64'(execute_payload_out[0].instruction_type), 64'(OP_IMMEDIATE));
    check("b0_alu", 64'(execute_payload_out[0].alu_operation), 64'(ALU_ADD));
    check("b0_imm", 64'(execute_payload_out[0].immediate), 64'hFFFF_FFFC);
    check("b0_l1_alu", 64'(execute_payload_out[1].alu_operation), 64'(ALU_OR));
    drive(b_m[4], b_l0[4], b_l1[4]);
    step(); step();
    check("held_occ", 64'(occupancy_out), 64'd4);
    execute_ready_in = 1'b1;
    step();
    execute_ready_in = 1'b0;
    check("after_deq_ready", 64'(fetch_ready_out), 64'd1);
    check("after_deq_occ", 64'(occupancy_out), 64'd3);
    check("b1_type", 64'(execute_payload_out[0].instruction_type), 64'(BRANCH));
    check("b1_br", 64'(execute_payload_out[0].branch_operation), 64'(BR_GE));
    check("b1_imm", 64'(execute_payload_out[0].immediate), 64'hFFFF_F810);
    check("b1_l1_imm", 64'(execute_payload_out[1].immediate), 64'h7F);
    step();
    check("refill_occ", 64'(occupancy_out), 64'd4);
    for (int i = 5; i < 10; i++) begin
      drive(b_m[i], b_l0[i], b_l1[i]);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        acc = fetch_ready_out;
        execute_ready_in = ~execute_ready_in;
        step();
      end
      if (!acc) check("enq_timeout", 64'(acc), 64'd1);
    end
    fetch_valid_in = 1'b0;
    execute_ready_in = 1'b1;
    repeat (8) step();

    // Streaming: one bundle per cycle in and out
    d0 = dut_deqs;
    fetch_valid_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, enc_r(4'h1, 3'(c % 7), 5'(c), 5'(c + 3), 5'(c + 9)), enc_i(4'h3, 3'b010, 5'(c), 5'd2, 12'(c)));
      step();
      check("stream_occ", 64'(occupancy_out), 64'd1);
    end
    check("stream_deqs", 64'(dut_deqs - d0), 64'd19);
    fetch_valid_in = 1'b0;
    step();

    // Unsupported counting
    check("cnt_before", 64'(unsupported_count_out), 64'd0);
    fetch_valid_in = 1'b1;
    drive(2'b11, 32'h0000_000F, 32'h0000_00FF);
    step();
    check("cnt_two", 64'(unsupported_count_out), 64'd2);
    drive(2'b01, 32'h0000_000F, 32'h0000_000F);
    step();
    check("cnt_masked", 64'(unsupported_count_out), 64'd3);
    drive(2'b11, enc_r(4'h1, 3'b111, 5'd1, 5'd1, 5'd1), enc_i(4'h3, 3'b000, 5'd1, 5'd1, 12'd0));
    step();
    check("cnt_funct", 64'(unsupported_count_out), 64'd5);
    fetch_valid_in = 1'b0;
    repeat (3) step();

    // Flush with occupancy 3 and a simultaneous enqueue
    execute_ready_in = 1'b0;
    fetch_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, b_l0[4 + i], b_l1[4 + i]);
      step();
    end
    check("pre_flush_occ", 64'(occupancy_out), 64'd3);
    drive(2'b11, 32'h0000_000F, 32'h0000_000F);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    fetch_valid_in = 1'b0;
    check("flush_occ", 64'(occupancy_out), 64'd0);
    check("flush_valid", 64'(execute_valid_out), 64'd0);
    check("flush_cnt", 64'(unsupported_count_out), 64'd5);
    step(); step();
    check("flush_still_empty", 64'(execute_valid_out), 64'd0);

    // All-zero mask: handshake without storage
    fetch_valid_in = 1'b1;
    drive(2'b01, b_l0[8], b_l1[8]);
    step();
    drive(2'b00, 32'h0000_000F, 32'h0000_000F);
    check("m00_ready", 64'(fetch_ready_out), 64'd1);
    step();
    fetch_valid_in = 1'b0;
    check("m00_occ", 64'(occupancy_out), 64'd1);
    check("m00_cnt", 64'(unsupported_count_out), 64'd5);
    execute_ready_in = 1'b1;
    step(); step();

    // Counter saturation via a long unsupported stream
    fetch_valid_in = 1'b1;
    drive(2'b11, 32'h0000_000F, 32'h0000_000F);
    guard = 0;
    while (m_cnt < 16'hFFFD && guard < 40000) begin step(); guard++; end
    drive(2'b01, 32'h0000_000F, 32'h0000_000F);
    while (m_cnt < 16'hFFFE && guard < 40000) begin step(); guard++; end
    if (guard >= 40000) check("sat_timeout", 64'(guard), 64'd0);
    check("cnt_fffe", 64'(unsupported_count_out), 64'hFFFE);
    drive(2'b11, 32'h0000_000F, 32'h0000_000F);
    step();
    check("cnt_sat", 64'(unsupported_count_out), 64'hFFFF);
    step();
    check("cnt_sat_hold", 64'(unsupported_count_out), 64'hFFFF);
    fetch_valid_in = 1'b0;
    step();

    // Asynchronous reset in the middle of a burst
    execute_ready_in = 1'b0;
    fetch_valid_in = 1'b1;
    drive(2'b11, b_l0[5], b_l1[5]);
    step(); step();
    check("pre_rst_occ", 64'(occupancy_out), 64'd2);
    #1 rst_in = 1'b0;
    #1;
    check("arst_valid", 64'(execute_valid_out), 64'd0);
    check("arst_mask", 64'(execute_mask_out), 64'd0);
    check("arst_occ", 64'(occupancy_out), 64'd0);
    check("arst_cnt", 64'(unsupported_count_out), 64'd0);
    check("arst_ready", 64'(fetch_ready_out), 64'd1);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    step();
    check("post_rst_occ", 64'(occupancy_out), 64'd1);
    check("post_rst_valid", 64'(execute_valid_out), 64'd1);
    fetch_valid_in = 1'b0;
    execute_ready_in = 1'b1;
    repeat (3) step();

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
